// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug readback path: frame header,
// dump FSM state encoding and a bytes-per-register helper.
package mips_dbg_pkg;

    localparam logic [7:0] DBG_HDR    = 8'hA5;
    localparam int         DBG_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_HDR     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_CSUM    = 3'd5,
        ST_DONE    = 3'd6
    } dbg_state_t;

    function automatic int dbg_bytes_per_reg(input int data_w);
        return data_w / DBG_BYTE_W;
    endfunction

endpackage

// File: rtl/dbg_tx_slot.sv
// One-entry output holding register for the debug byte stream. Once a byte
// is presented it stays put until the sink takes it.
module dbg_tx_slot (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_free
);

    logic [7:0] r_data;
    logic       r_valid;

    // Free when empty or when the held byte transfers on this edge.
    assign o_free  = !r_valid || i_ready;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dumper.sv
// Debug readback engine: stalls the core, reads every register through a
// dedicated read port and streams a framed, XOR-checksummed byte dump.
module regfile_dumper
    import mips_dbg_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_req,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int BYTES  = dbg_bytes_per_reg(DATA_W);
    localparam int BCNT_W = $clog2(BYTES + 1);
    localparam int HCNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    dbg_state_t          r_state;
    logic [HCNT_W-1:0]   r_hcnt;
    logic [ADDR_W-1:0]   r_k;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [DATA_W-1:0]   r_shift;
    logic [7:0]          r_csum;

    logic                w_xfer;
    logic                w_slot_free;
    logic                w_load_req;
    logic                w_load;
    logic [7:0]          w_load_data;
    logic [7:0]          w_csum_next;
    logic                w_last_reg;

    assign w_xfer      = tx_valid && tx_ready;
    assign w_csum_next = r_csum ^ tx_data;
    assign w_last_reg  = (r_k == ADDR_W'(NUM_REGS - 1));
    assign w_load      = w_load_req && w_slot_free;

    assign busy     = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign cpu_hold = busy;
    assign done     = (r_state == ST_DONE);
    assign rf_raddr = r_k;

    // Byte to present next; the checksum byte already folds in the last data byte.
    always_comb begin
        w_load_req  = 1'b0;
        w_load_data = 8'h00;
        case (r_state)
            ST_HOLD: begin
                if (r_hcnt == '0) begin
                    w_load_req  = 1'b1;
                    w_load_data = DBG_HDR;
                end
            end
            ST_CAPTURE: begin
                w_load_req  = 1'b1;
                w_load_data = 8'(r_k);
            end
            ST_SEND: begin
                if (w_xfer) begin
                    if (r_bcnt != '0) begin
                        w_load_req  = 1'b1;
                        w_load_data = r_shift[DATA_W-1 -: 8];
                    end else if (w_last_reg) begin
                        w_load_req  = 1'b1;
                        w_load_data = w_csum_next;
                    end
                end
            end
            default: begin
                w_load_req  = 1'b0;
                w_load_data = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
            r_k     <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_csum  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dump_req) begin
                        r_state <= ST_HOLD;
                        r_hcnt  <= HCNT_W'(HOLD_CYC - 1);
                    end
                end
                ST_HOLD: begin
                    if (r_hcnt == '0) begin
                        r_state <= ST_HDR;
                        r_csum  <= 8'h00;
                    end else begin
                        r_hcnt <= r_hcnt - HCNT_W'(1);
                    end
                end
                ST_HDR: begin
                    if (w_xfer) begin
                        r_k     <= '0;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_shift <= rf_rdata;
                    r_bcnt  <= BCNT_W'(BYTES);
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_csum <= w_csum_next;
                        if (r_bcnt != '0) begin
                            r_shift <= r_shift << 8;
                            r_bcnt  <= r_bcnt - BCNT_W'(1);
                        end else if (w_last_reg) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_k     <= r_k + ADDR_W'(1);
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_xfer) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_k     <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    dbg_tx_slot u_tx_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (tx_ready),
        .o_data  (tx_data),
        .o_valid (tx_valid),
        .o_free  (w_slot_free)
    );

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: reset, identity/value dumps, back-pressure,
// repeated requests and reset mid-frame, checked against hand-computed frames.
module tb_regfile_dumper;

    logic        clk;
    logic        reset;
    logic        dump_req;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] regs [32];
    assign rf_rdata = regs[rf_raddr];

    regfile_dumper #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .DATA_W   (32),
        .HOLD_CYC (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dump_req (dump_req),
        .busy     (busy),
        .done     (done),
        .cpu_hold (cpu_hold),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] rx [$];
    logic [7:0] exp_q [$];
    int         done_cnt, busy_cyc, first_valid_cyc, stalls, hold_drops;
    int         rdy_mode;
    bit         req_next, req_in_done, prev_stall, prev_busy;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One negedge: drive inputs for the coming edge, then observe the DUT.
    task automatic tick();
        @(negedge clk);
        cyc++;
        dump_req = req_next;
        req_next = 1'b0;
        tx_ready = (rdy_mode == 0) ? 1'b1 : ~tx_ready;
        if (prev_stall) begin
            check("stable_valid", {31'd0, tx_valid}, 32'd1);
            check("stable_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_data  = tx_data;
        if (tx_valid && tx_ready && !reset) rx.push_back(tx_data);
        if (busy && !prev_busy && busy_cyc < 0) busy_cyc = cyc;
        prev_busy = busy;
        if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (busy_cyc >= 0 && done_cnt == 0 && !done) begin
            if (tx_valid && !tx_ready) stalls++;
            if (!cpu_hold) hold_drops++;
        end
        if (done) begin
            done_cnt++;
            if (req_in_done) dump_req = 1'b1;
        end
    endtask

    task automatic clear_obs();
        rx.delete();
        done_cnt = 0; busy_cyc = -1; first_valid_cyc = -1;
        stalls = 0; hold_drops = 0; prev_busy = 1'b0;
    endtask

    task automatic build_expected();
        logic [7:0] cs;
        logic [31:0] v;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back(8'(k));
            cs = cs ^ 8'(k);
            v = regs[k];
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(v[b*8 +: 8]);
                cs = cs ^ v[b*8 +: 8];
            end
        end
        exp_q.push_back(cs);
    endtask

    task automatic run_dump(input int mode, input bit rereq, input bit req_done);
        clear_obs();
        rdy_mode    = mode;
        req_in_done = req_done;
        req_next    = 1'b1;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            tick();
            if (rereq && busy_cyc >= 0 && (cyc - busy_cyc) == 50) req_next = 1'b1;
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        tick();
        req_in_done = 1'b0;
    endtask

    task automatic compare_frame(input string name);
        check({name, "_len"}, rx.size(), 32'd162);
        for (int i = 0; i < 162 && i < rx.size(); i++)
            check($sformatf("%s_byte%0d", name, i), {24'd0, rx[i]}, {24'd0, exp_q[i]});
        $display("frame %s: %0d bytes, csum 0x%02h, busy@%0d done_cnt %0d",
                 name, rx.size(), (rx.size() > 0) ? rx[rx.size()-1] : 8'h00, busy_cyc, done_cnt);
    endtask

    initial begin
        reset = 1'b1; dump_req = 1'b0; tx_ready = 1'b1; rdy_mode = 0;
        req_next = 1'b0; req_in_done = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
        for (int k = 0; k < 32; k++) regs[k] = 32'(k);
        clear_obs();

        // Reset held 10 cycles with a request pulse inside it.
        for (int i = 0; i < 10; i++) begin
            if (i == 3) req_next = 1'b1;
            tick();
        end
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_raddr", {27'd0, rf_raddr}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("rst_no_frame", rx.size(), 32'd0);
        check("rst_idle_busy", {31'd0, busy}, 32'd0);

        // Identity dump at full rate.
        build_expected();
        run_dump(0, 1'b0, 1'b0);
        compare_frame("identity");
        check("identity_csum", {24'd0, rx[161]}, 32'h00);
        check("hdr_latency", first_valid_cyc - busy_cyc, 32'd4);
        check("done_cycle", done_cnt > 0 ? 32'(cyc - 1 - busy_cyc + 1) : 32'd0, 32'd199);
        check("done_pulses", done_cnt, 32'd1);

        // R31 value ordering, MSB first.
        regs[31] = 32'hDEADBEEF;
        build_expected();
        run_dump(0, 1'b0, 1'b0);
        compare_frame("deadbeef");
        check("r31_idx", {24'd0, rx[156]}, 32'h1F);
        check("r31_b3", {24'd0, rx[157]}, 32'hDE);
        check("r31_b2", {24'd0, rx[158]}, 32'hAD);
        check("r31_b1", {24'd0, rx[159]}, 32'hBE);
        check("r31_b0", {24'd0, rx[160]}, 32'hEF);
        check("deadbeef_csum", {24'd0, rx[161]}, 32'h3D);
        regs[31] = 32'd31;

        // Back-pressure: tx_ready toggles every cycle.
        build_expected();
        run_dump(1, 1'b0, 1'b0);
        compare_frame("backpressure");
        check("bp_hold_drops", hold_drops, 32'd0);
        check("bp_stalls_seen", {31'd0, stalls > 0}, 32'd1);
        check("bp_done_cycle", 32'(cyc - 1 - busy_cyc + 1), 32'(199 + stalls));

        // Re-requests at cycle 50 and in the done cycle must be ignored.
        rdy_mode = 0;
        run_dump(0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) tick();
        compare_frame("rereq");
        check("rereq_done_pulses", done_cnt, 32'd1);
        check("rereq_idle_busy", {31'd0, busy}, 32'd0);

        // Reset after byte 40 abandons the frame; the next dump is complete.
        clear_obs();
        req_next = 1'b1;
        for (int i = 0; i < 500 && rx.size() < 40; i++) tick();
        check("mid_reached40", rx.size(), 32'd40);
        reset = 1'b1;
        tick();
        check("mid_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_hold", {31'd0, cpu_hold}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_no_done", done_cnt, 32'd0);
        run_dump(0, 1'b0, 1'b0);
        compare_frame("after_reset");
        check("after_reset_hdr", {24'd0, rx[0]}, 32'hA5);
        check("after_reset_csum", {24'd0, rx[161]}, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug readback engine for the pipelined MIPS core. On request it stalls the core, reads every architectural register through a dedicated register-file read port, and streams the contents out as a framed byte stream over a valid/ready interface. It is the readback path that matches the program-load path into instruction memory, and it replaces hierarchical peeking at the register file in benches and on hardware.

## Interface

**Parameters**
- `NUM_REGS`, default 32: number of registers dumped (R0..R31).
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register width. Must be a multiple of 8.
- `HOLD_CYC`, default 4: drain cycles between asserting `cpu_hold` and the first read. Must be ≥1.

**Ports**
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `dump_req`, in, 1: start a dump. Sampled only in IDLE.
- `busy`, out, 1: high from the cycle after an accepted request until the frame completes.
- `done`, out, 1: one-cycle pulse after the checksum byte is accepted.
- `cpu_hold`, out, 1: stalls the pipeline (PC and all pipeline registers frozen). Same timing as `busy`.
- `rf_raddr`, out, ADDR_W: register-file debug read address.
- `rf_rdata`, in, DATA_W: register-file debug read data. Combinational, valid in the same cycle as `rf_raddr`.
- `tx_data`, out, 8: stream byte.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: sink accepts. A byte transfers on a rising edge when `tx_valid && tx_ready`.

## Operation

- **Reset values:** `busy`=0, `done`=0, `cpu_hold`=0, `tx_valid`=0, `tx_data`=0, `rf_raddr`=0, state IDLE, checksum 0.
- **Frame format:**
  - Header 0xA5.
  - For each k in 0..NUM_REGS-1: index byte k, then DATA_W/8 data bytes, MSB first.
  - Checksum byte: XOR of every byte after the header, excluding itself.
  - With defaults the frame is 1+32×5+1 = 162 bytes.
- **States:**
  - IDLE: if `dump_req`, go to HOLD and load the hold counter.
  - HOLD: hold for HOLD_CYC cycles, then go to HDR.
  - HDR: present 0xA5. On transfer, set k=0 and go to CAPTURE.
  - CAPTURE: drive `rf_raddr`=k and latch `rf_rdata` into the shift register. Lasts one cycle, with `tx_valid`=0. Then go to SEND.
  - SEND: present the index byte, then the data bytes. Advance only on transfer. After the last byte, go to CAPTURE with k+1, or go to CSUM when k=NUM_REGS-1.
  - CSUM: present the checksum. On transfer, go to DONE.
  - DONE: `done`=1, `busy`=0, `cpu_hold`=0 for one cycle, then return to IDLE.
- **Handshake:**
  - While `tx_valid` is high and `tx_ready` is low, `tx_data` stays stable and `tx_valid` cannot drop.
  - `tx_valid` never depends combinationally on `tx_ready`.
- **Ignored requests:** `dump_req` is ignored outside IDLE. A request in the DONE cycle is also ignored.
- **Checksum:** the register clears on entering HDR and accumulates on each transferred byte in SEND.
- **Reset mid-frame:** the block returns to the reset values on the next edge. The partial frame is abandoned and no `done` pulse is produced.
- **Register reads:** R0 is dumped exactly as the register file returns it. No forcing to zero.
- **Core interaction:** the core must honour `cpu_hold` so that register contents are frozen for the whole dump.

## Timing

- Let the request be sampled at edge N.
  - `busy` and `cpu_hold` rise at N+1.
  - The header is valid at N+1+HOLD_CYC.
- With `tx_ready` held high and defaults: HOLD 4 + HDR 1 + 32×(1 CAPTURE + 5 SEND) + CSUM 1 = 198 cycles from `busy` rising to the checksum transfer. `done` asserts the cycle after the checksum transfer.
- Each back-pressure cycle adds exactly one cycle to the total.

## Structure

- **Shared package `mips_dbg_pkg`:**
  - Header constant `DBG_HDR`=8'hA5.
  - State enum (IDLE, HOLD, HDR, CAPTURE, SEND, CSUM, DONE).
  - Helper constant for bytes per register.
- **Sub-module `dbg_tx_slot`:** one-entry output holding register that owns `tx_data`/`tx_valid` and the stability rule. The FSM loads it only when it is empty or the current byte is transferring.
- **Top-level wiring:** the top level connects `cpu_hold` to the PC and pipeline-register enables, and `rf_raddr`/`rf_rdata` to a third read port on `reg_file`.

## Test plan

- **Reset:** assert `reset` for 10 cycles. All outputs read 0. Pulse `dump_req` during reset; no frame is produced.
- **Identity dump:** preload Rk=k, `tx_ready`=1, pulse `dump_req`.
  - Expect the stream A5, 00 00 00 00 00, 01 00 00 00 01, … 1F 00 00 00 1F, then checksum 00.
  - Total 162 bytes.
  - `done` arrives 199 cycles after `busy` rises.
- **Value ordering:** with R31=32'hDEADBEEF and all others Rk=k, the R31 bytes read 1F DE AD BE EF and the checksum reads 3D.
- **Back-pressure:** toggle `tx_ready` every cycle and run the identity dump.
  - The byte sequence is identical.
  - `tx_data` stays stable whenever `tx_valid && !tx_ready`.
  - `cpu_hold` stays high throughout.
- **Repeated request:** re-pulse `dump_req` at cycle 50 of a dump and again in the `done` cycle. Exactly one 162-byte frame is produced.
- **Reset mid-frame:** assert `reset` after byte 40.
  - `tx_valid`, `cpu_hold` and `busy` read 0 on the next cycle.
  - A new `dump_req` yields a complete frame starting at A5 with the correct checksum.
